// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the snake game sequencer and the rest of the snake pipeline.
// The slave side is the sequencer itself; the master side drives its inputs.
interface snake_game_ctrl_if;
  logic       vblnk_in;
  logic [3:0] btn;
  logic [3:0] score;
  logic       game_over;
  logic       victory;
  logic       move_tick;
  logic       game_rst;
  logic [1:0] state;
  logic       show_game_over;
  logic       show_you_win;

  modport master (
    output vblnk_in, btn, score, game_over, victory,
    input  move_tick, game_rst, state, show_game_over, show_you_win
  );

  modport slave (
    input  vblnk_in, btn, score, game_over, victory,
    output move_tick, game_rst, state, show_game_over, show_you_win
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/PLAY/OVER/WIN state, per-frame step pacing scaled by score,
// game-logic reset and overlay selects.
module snake_game_ctrl #(
  parameter int unsigned FRAMES_PER_STEP_INIT = 30,
  parameter int unsigned FRAMES_PER_STEP_MIN  = 8,
  parameter int unsigned SPEED_STEP           = 2,
  parameter int unsigned END_HOLD_FRAMES      = 120
) (
  input logic               pclk,
  input logic               rst,
  snake_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StOver = 2'b10,
    StWin  = 2'b11
  } state_e;

  state_e      r_state;
  logic        r_vblnk_q;
  logic [3:0]  r_btn_s1;
  logic [3:0]  r_btn_s2;
  logic [3:0]  r_btn_s3;
  logic [7:0]  r_fcnt;
  logic [7:0]  r_period;
  logic [7:0]  r_hold;
  logic        r_move_tick;
  logic        r_game_rst;
  logic        r_show_go;
  logic        r_show_win;

  logic              w_frame_start;
  logic              w_btn_rise;
  logic              w_step_due;
  logic              w_hold_done;
  logic signed [9:0] w_period_raw;
  logic [7:0]        w_period_next;

  // Register vblank for edge detection and pass buttons through a 2-flop sync plus edge stage.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      r_vblnk_q <= 1'b0;
      r_btn_s1  <= 4'd0;
      r_btn_s2  <= 4'd0;
      r_btn_s3  <= 4'd0;
    end else begin
      r_vblnk_q <= bus.vblnk_in;
      r_btn_s1  <= bus.btn;
      r_btn_s2  <= r_btn_s1;
      r_btn_s3  <= r_btn_s2;
    end
  end

  assign w_frame_start = bus.vblnk_in & ~r_vblnk_q;
  assign w_btn_rise    = |(r_btn_s2 & ~r_btn_s3);
  assign w_step_due    = w_frame_start && (r_fcnt == r_period - 8'd1);
  assign w_hold_done   = (r_hold == 8'(END_HOLD_FRAMES));

  // Step period from the current score; signed so a large score clamps instead of wrapping.
  always_comb begin
    w_period_raw  = $signed(10'(FRAMES_PER_STEP_INIT))
                  - $signed(10'(SPEED_STEP) * {6'd0, bus.score});
    w_period_next = w_period_raw[7:0];
    if (w_period_raw < $signed(10'(FRAMES_PER_STEP_MIN))) begin
      w_period_next = 8'(FRAMES_PER_STEP_MIN);
    end
  end

  // Game FSM with frame/hold counters and registered outputs; end flags win over a due step.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_fcnt      <= 8'd0;
      r_period    <= 8'(FRAMES_PER_STEP_INIT);
      r_hold      <= 8'd0;
      r_move_tick <= 1'b0;
      r_game_rst  <= 1'b1;
      r_show_go   <= 1'b0;
      r_show_win  <= 1'b0;
    end else begin
      r_move_tick <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_btn_rise) begin
            r_state    <= StPlay;
            r_fcnt     <= 8'd0;
            r_period   <= w_period_next;
            r_game_rst <= 1'b0;
          end
        end
        StPlay: begin
          if (bus.victory) begin
            r_state    <= StWin;
            r_hold     <= 8'd0;
            r_show_win <= 1'b1;
          end else if (bus.game_over) begin
            r_state   <= StOver;
            r_hold    <= 8'd0;
            r_show_go <= 1'b1;
          end else if (w_step_due) begin
            r_fcnt      <= 8'd0;
            r_move_tick <= 1'b1;
            r_period    <= w_period_next;
          end else if (w_frame_start) begin
            r_fcnt <= r_fcnt + 8'd1;
          end
        end
        StOver, StWin: begin
          // Presses before the hold expires are dropped, not remembered.
          if (w_btn_rise && w_hold_done) begin
            r_state    <= StIdle;
            r_game_rst <= 1'b1;
            r_show_go  <= 1'b0;
            r_show_win <= 1'b0;
          end else if (w_frame_start && !w_hold_done) begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.state          = r_state;
  assign bus.move_tick      = r_move_tick;
  assign bus.game_rst       = r_game_rst;
  assign bus.show_game_over = r_show_go;
  assign bus.show_you_win   = r_show_win;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a frame-level reference model.
module tb_snake_game_ctrl;
  localparam int unsigned INIT = 30;
  localparam int unsigned MINP = 8;
  localparam int unsigned STEP = 2;
  localparam int unsigned HOLD = 120;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  always #5 pclk = ~pclk;

  snake_game_ctrl_if bus ();

  snake_game_ctrl #(
    .FRAMES_PER_STEP_INIT (INIT),
    .FRAMES_PER_STEP_MIN  (MINP),
    .SPEED_STEP           (STEP),
    .END_HOLD_FRAMES      (HOLD)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {state, move_tick, game_rst, show_game_over, show_you_win}
  function automatic logic [5:0] outs();
    return {bus.state, bus.move_tick, bus.game_rst, bus.show_game_over, bus.show_you_win};
  endfunction

  // Tick monitor: count ticks and flag any tick wider than one cycle.
  int   tick_cnt  = 0;
  int   width_err = 0;
  logic prev_tick = 1'b0;
  always @(negedge pclk) begin
    if (bus.move_tick === 1'b1) begin
      tick_cnt <= tick_cnt + 1;
      if (prev_tick) width_err <= width_err + 1;
    end
    prev_tick <= (bus.move_tick === 1'b1);
  end

  // Reference model: game state and frame counting in plain integers.
  bit         model_en = 1'b0;
  int         m_state;   // 0 idle, 1 play, 2 over, 3 win
  int         m_frames;  // frames seen since start or last step
  int         m_period;
  int         m_hold;
  bit         m_tick;
  bit         m_vb;
  logic [3:0] m_bq[$];   // button samples, newest first

  function automatic int calc_period(input int s);
    int p;
    p = int'(INIT) - int'(STEP) * s;
    return (p < int'(MINP)) ? int'(MINP) : p;
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_frames = 0;
    m_period = INIT;
    m_hold   = 0;
    m_tick   = 0;
    m_vb     = 0;
    m_bq     = '{4'd0, 4'd0, 4'd0};
  endtask

  task automatic model_step();
    bit fs;
    bit rise;
    fs     = bus.vblnk_in && !m_vb;
    rise   = |(m_bq[1] & ~m_bq[2]);
    m_tick = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    case (m_state)
      0: if (rise) begin
        m_state  = 1;
        m_frames = 0;
        m_period = calc_period(int'(bus.score));
      end
      1: begin
        if (bus.victory) begin
          m_state = 3;
          m_hold  = 0;
        end else if (bus.game_over) begin
          m_state = 2;
          m_hold  = 0;
        end else if (fs) begin
          m_frames++;
          if (m_frames == m_period) begin
            m_tick   = 1;
            m_frames = 0;
            m_period = calc_period(int'(bus.score));
          end
        end
      end
      default: begin
        if (rise && m_hold == int'(HOLD)) m_state = 0;
        else if (fs && m_hold < int'(HOLD)) m_hold++;
      end
    endcase
    m_vb = bus.vblnk_in;
    m_bq.push_front(bus.btn);
    void'(m_bq.pop_back());
  endtask

  // One clock: model sees the inputs that the coming edge samples; outputs checked after it.
  task automatic cyc1();
    if (model_en) model_step();
    @(negedge pclk);
    #1;
    if (model_en) begin
      check("model", {26'd0, outs()},
            {26'd0, m_state[1:0], m_tick, m_state == 0, m_state == 2, m_state == 3});
    end
  endtask

  int frame_no = 0;
  int late_err = 0;
  int tick_frames[$];

  task automatic frame();
    int t_start;
    int t_first;
    t_start = tick_cnt;
    bus.vblnk_in = 1'b0;
    repeat (4) cyc1();
    bus.vblnk_in = 1'b1;
    cyc1();
    t_first = tick_cnt;
    cyc1();
    if (tick_cnt != t_first) late_err++;
    frame_no++;
    if (tick_cnt != t_start) tick_frames.push_back(frame_no);
  endtask

  task automatic press(input logic [3:0] b);
    bus.btn = b;
    repeat (2) cyc1();
    bus.btn = 4'd0;
    repeat (2) cyc1();
  endtask

  typedef struct {
    logic       r;
    logic       vb;
    logic [3:0] b;
    logic       go;
    logic       vic;
    logic [5:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic vb, input logic [3:0] b,
                              input logic go, input logic vic, input logic [1:0] st,
                              input logic tk, input logic gr, input logic sg, input logic sw);
    vec_t v;
    v.r   = r;
    v.vb  = vb;
    v.b   = b;
    v.go  = go;
    v.vic = vic;
    v.exp = {st, tk, gr, sg, sw};
    return v;
  endfunction

  vec_t vecs[21];
  int   exp_ticks[8] = '{30, 60, 90, 120, 144, 168, 176, 184};
  int   t0;
  int   vb_left;

  initial begin
    //          rst vb btn   go vic  st   tk gr sg sw
    vecs[0]  = mk(0, 0, 4'h0, 0, 0, 2'd0, 0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 4'h0, 0, 0, 2'd0, 0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 4'h0, 0, 0, 2'd0, 0, 1, 0, 0);
    vecs[3]  = mk(1, 0, 4'h1, 0, 0, 2'd0, 0, 1, 0, 0);
    vecs[4]  = mk(1, 0, 4'h1, 0, 0, 2'd0, 0, 1, 0, 0);
    vecs[5]  = mk(1, 0, 4'h0, 0, 0, 2'd1, 0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 4'h0, 0, 0, 2'd1, 0, 0, 0, 0);
    vecs[7]  = mk(1, 1, 4'h0, 0, 0, 2'd1, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 4'h0, 1, 1, 2'd3, 0, 0, 0, 1);
    vecs[9]  = mk(1, 0, 4'h0, 0, 0, 2'd3, 0, 0, 0, 1);
    vecs[10] = mk(1, 0, 4'h2, 0, 0, 2'd3, 0, 0, 0, 1);
    vecs[11] = mk(1, 0, 4'h2, 0, 0, 2'd3, 0, 0, 0, 1);
    vecs[12] = mk(1, 0, 4'h0, 0, 0, 2'd3, 0, 0, 0, 1);
    vecs[13] = mk(1, 1, 4'h0, 0, 0, 2'd3, 0, 0, 0, 1);
    vecs[14] = mk(1, 1, 4'h0, 0, 0, 2'd3, 0, 0, 0, 1);
    vecs[15] = mk(0, 0, 4'h0, 0, 0, 2'd0, 0, 1, 0, 0);
    vecs[16] = mk(1, 0, 4'h8, 0, 0, 2'd0, 0, 1, 0, 0);
    vecs[17] = mk(1, 0, 4'h8, 0, 0, 2'd0, 0, 1, 0, 0);
    vecs[18] = mk(1, 0, 4'h0, 0, 0, 2'd1, 0, 0, 0, 0);
    vecs[19] = mk(1, 0, 4'h0, 1, 0, 2'd2, 0, 0, 1, 0);
    vecs[20] = mk(1, 0, 4'h0, 0, 1, 2'd2, 0, 0, 1, 0);

    bus.vblnk_in  = 1'b0;
    bus.btn       = 4'd0;
    bus.score     = 4'd0;
    bus.game_over = 1'b0;
    bus.victory   = 1'b0;
    @(negedge pclk);
    #1;

    // Vector table
    for (int i = 0; i < 21; i++) begin
      rst           = vecs[i].r;
      bus.vblnk_in  = vecs[i].vb;
      bus.btn       = vecs[i].b;
      bus.game_over = vecs[i].go;
      bus.victory   = vecs[i].vic;
      cyc1();
      check($sformatf("vec%0d", i), {26'd0, outs()}, {26'd0, vecs[i].exp});
    end
    bus.game_over = 1'b0;
    bus.victory   = 1'b0;

    // Reset, then idle frames produce nothing
    rst = 1'b0;
    repeat (3) cyc1();
    check("reset_outs", {26'd0, outs()}, {26'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    rst = 1'b1;
    t0  = tick_cnt;
    repeat (5) frame();
    check("idle_no_tick", tick_cnt - t0, 0);
    check("idle_state", {30'd0, bus.state}, 0);

    // Start: state changes on the third edge
    bus.btn = 4'b0001;
    cyc1();
    cyc1();
    check("btn_edge2", {30'd0, bus.state}, 0);
    bus.btn = 4'd0;
    cyc1();
    check("btn_edge3", {29'd0, bus.state, bus.game_rst}, {29'd0, 2'd1, 1'b0});

    // Pacing at score 0, mid-period score change, clamp at score 15
    frame_no = 0;
    tick_frames.delete();
    repeat (90) frame();
    check("ticks_in_90", tick_frames.size(), 3);
    repeat (10) frame();
    bus.score = 4'd3;
    repeat (44) frame();
    bus.score = 4'd15;
    repeat (40) frame();
    check("tick_count", tick_frames.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < tick_frames.size()) check($sformatf("tick_frame%0d", i), tick_frames[i], exp_ticks[i]);
    end

    // Game over and hold window
    repeat (3) frame();
    t0 = tick_cnt;
    bus.game_over = 1'b1;
    cyc1();
    check("over_entry", {28'd0, bus.state, bus.show_game_over, bus.show_you_win},
          {28'd0, 2'd2, 1'b1, 1'b0});
    bus.game_over = 1'b0;
    repeat (50) frame();
    press(4'b0100);
    check("over_btn50", {30'd0, bus.state}, 2);
    repeat (69) frame();
    press(4'b0010);
    check("over_btn119", {30'd0, bus.state}, 2);
    frame();
    press(4'b1000);
    check("over_btn120", {29'd0, bus.state, bus.game_rst}, {29'd0, 2'd0, 1'b1});
    check("over_no_tick", tick_cnt - t0, 0);

    // Victory and game over together on a pending tick
    bus.score = 4'd0;
    press(4'b0001);
    t0 = tick_cnt;
    repeat (29) frame();
    bus.vblnk_in = 1'b0;
    repeat (4) cyc1();
    bus.vblnk_in  = 1'b1;
    bus.game_over = 1'b1;
    bus.victory   = 1'b1;
    cyc1();
    check("sim_end", {26'd0, outs()}, {26'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1});
    bus.game_over = 1'b0;
    bus.victory   = 1'b0;
    repeat (3) cyc1();
    check("sim_end_no_tick", tick_cnt - t0, 0);

    // Reset one cycle before a tick
    rst = 1'b0;
    cyc1();
    rst = 1'b1;
    press(4'b0001);
    t0 = tick_cnt;
    repeat (29) frame();
    bus.vblnk_in = 1'b0;
    repeat (4) cyc1();
    bus.vblnk_in = 1'b1;
    rst = 1'b0;
    cyc1();
    check("rst_mid", {26'd0, outs()}, {26'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    rst = 1'b1;
    repeat (3) cyc1();
    check("rst_mid_no_tick", tick_cnt - t0, 0);
    press(4'b0001);
    t0 = tick_cnt;
    repeat (29) frame();
    check("restart_29", tick_cnt - t0, 0);
    frame();
    check("restart_30", tick_cnt - t0, 1);

    check("tick_latency", late_err, 0);
    check("tick_width", width_err, 0);

    // Randomized run against the reference model
    rst = 1'b0;
    bus.vblnk_in = 1'b0;
    bus.btn      = 4'd0;
    cyc1();
    model_reset();
    rst      = 1'b1;
    model_en = 1'b1;
    vb_left  = 4;
    for (int c = 0; c < 30000; c++) begin
      if (vb_left == 0) begin
        bus.vblnk_in = ~bus.vblnk_in;
        vb_left = bus.vblnk_in ? int'($urandom_range(1, 4)) : int'($urandom_range(3, 8));
      end
      vb_left--;
      if ($urandom_range(0, 39) == 0) bus.btn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) bus.score = 4'($urandom_range(0, 15));
      bus.game_over = ($urandom_range(0, 1499) == 0);
      bus.victory   = ($urandom_range(0, 2999) == 0);
      rst           = ($urandom_range(0, 7999) != 0);
      cyc1();
    end
    model_en = 1'b0;
    check("rand_width", width_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
